pipe_ctrl_seq: RTL and testbench

- Parametrised, sequential successor of the combinational pipeline controller.
- Merges N prioritised stall sources into a per-stage stall vector; each source has its own stage mask.
- Exceptions are latched, held back while memory is still outstanding, then emitted as a one-cycle flush followed by a valid/ready redirect to fetch.
- Sits between the EX/MEM/cache stall sources, CP0 exception logic and the PC/IF stage.

---
 rtl/pipe_ctrl_seq_pkg.sv | 32 +++
 rtl/pipe_ctrl_seq_exc_vec_decode.sv | 27 ++
 rtl/pipe_ctrl_seq.sv | 114 +++++++++++
 tb/tb_pipe_ctrl_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_seq_pkg.sv
// rtl/pipe_ctrl_seq_pkg.sv - shared constants, state encoding and widths for the pipeline controller
package pipe_ctrl_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  localparam int STALL_BUS_W = 9;

  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL    = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES    = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS     = 32'h0000_0008;
  localparam logic [31:0] EXC_BP      = 32'h0000_0009;
  localparam logic [31:0] EXC_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TR      = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;
  localparam logic [31:0] EXC_SRST    = 32'h0000_0011;
  localparam logic [31:0] EXC_CPU     = 32'h0000_0012;
  localparam logic [31:0] EXC_NMI     = 32'h0000_0013;
  localparam logic [31:0] EXC_IBE     = 32'h0000_0014;
  localparam logic [31:0] EXC_DBE     = 32'h0000_0015;
  localparam logic [31:0] EXC_REFETCH = 32'hffff_ffff;

  localparam logic [31:0] EXC_VEC_DEF = 32'hbfc0_0380;
  localparam logic [31:0] RST_VEC_DEF = 32'hbfc0_0200;

endpackage

// File: rtl/pipe_ctrl_seq_exc_vec_decode.sv
// rtl/pipe_ctrl_seq_exc_vec_decode.sv - combinational exception code to redirect target mapping
module exc_vec_decode
  import pipe_ctrl_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF,
  parameter logic [31:0] RST_VEC = RST_VEC_DEF
) (
  input  logic [31:0] i_excepttype,
  input  logic [31:0] i_cp0_epc,
  input  logic [31:0] i_current_pc,
  output logic [31:0] o_target
);

  always_comb begin
    o_target = 32'h0;
    case (i_excepttype)
      EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI,
      EXC_OV, EXC_TR, EXC_CPU, EXC_IBE, EXC_DBE: o_target = EXC_VEC;
      EXC_ERET:           o_target = i_cp0_epc;
      EXC_SRST, EXC_NMI:  o_target = RST_VEC;
      // refetch wraps modulo 2^32 by construction of the 32-bit add
      EXC_REFETCH:        o_target = i_current_pc + 32'd4;
      default:            o_target = 32'h0;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_seq.sv
// rtl/pipe_ctrl_seq.sv - prioritised stall merge plus exception flush/redirect sequencer
module pipe_ctrl_seq
  import pipe_ctrl_seq_pkg::*;
#(
  parameter int                              NUM_STAGES   = STALL_BUS_W,
  parameter int                              NUM_SRC      = 5,
  parameter logic [NUM_SRC*NUM_STAGES-1:0]   STALL_MASKS  = {9'h0FF, 9'h0FF, 9'h0FF, 9'h01F, 9'h00F},
  parameter logic [NUM_SRC-1:0]              MEM_SRC_MASK = 5'b00110,
  parameter logic [31:0]                     EXC_VEC      = EXC_VEC_DEF,
  parameter logic [31:0]                     RST_VEC      = RST_VEC_DEF,
  parameter int                              CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_SRC-1:0]    stallreq_i,
  input  logic [31:0]           excepttype_i,
  input  logic [31:0]           cp0_epc_i,
  input  logic [31:0]           current_pc_i,
  input  logic                  redirect_ready_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic                  flush_o,
  output logic [31:0]           new_pc_o,
  output logic                  redirect_valid_o,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      stall_cycles_o
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [31:0]           r_new_pc;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [NUM_STAGES-1:0] w_req_stall;
  logic [31:0]           w_target;
  logic                  w_exc;
  logic                  w_mem_pend;

  assign w_exc      = (excepttype_i != 32'h0);
  assign w_mem_pend = ((stallreq_i & MEM_SRC_MASK) != '0);

  // Masks are listed source 0 first, so source i lives at the i-th slice from the MSB end.
  always_comb begin
    w_req_stall = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (stallreq_i[i]) begin
        w_req_stall = w_req_stall | STALL_MASKS[(NUM_SRC-1-i)*NUM_STAGES +: NUM_STAGES];
      end
    end
  end

  exc_vec_decode #(
    .EXC_VEC (EXC_VEC),
    .RST_VEC (RST_VEC)
  ) u_exc_vec_decode (
    .i_excepttype (excepttype_i),
    .i_cp0_epc    (cp0_epc_i),
    .i_current_pc (current_pc_i),
    .o_target     (w_target)
  );

  always_comb begin
    w_state_nxt = r_state;
    stall_o     = w_req_stall;
    case (r_state)
      ST_RUN: begin
        if (w_exc) begin
          w_state_nxt = w_mem_pend ? ST_WAIT_MEM : ST_FLUSH;
        end
      end
      ST_WAIT_MEM: begin
        stall_o = '1;
        if (!w_mem_pend) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        stall_o     = '0;
        w_state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        stall_o[0] = 1'b1;
        if (redirect_ready_i) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_RUN;
      r_new_pc    <= 32'h0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Only a capture from RUN loads the target, so the first exception wins.
      if (r_state == ST_RUN && w_exc) begin
        r_new_pc <= w_target;
      end else if (r_state == ST_REDIRECT && redirect_ready_i) begin
        r_new_pc <= 32'h0;
      end
      if (stall_o != '0 && r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign flush_o          = (r_state == ST_FLUSH);
  assign redirect_valid_o = (r_state == ST_REDIRECT);
  assign busy_o           = (r_state != ST_RUN);
  assign new_pc_o         = r_new_pc;
  assign stall_cycles_o   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// tb/tb_pipe_ctrl_seq.sv - self-checking bench for pipe_ctrl_seq
module tb_pipe_ctrl_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  stallreq_i;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [31:0] current_pc_i;
  logic        redirect_ready_i;
  logic [8:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        redirect_valid_o;
  logic        busy_o;
  logic [31:0] stall_cycles_o;

  logic [8:0]  s_stall_o;
  logic        s_flush_o;
  logic [31:0] s_new_pc_o;
  logic        s_redirect_valid_o;
  logic        s_busy_o;
  logic [3:0]  s_stall_cycles_o;

  always #5 clk = ~clk;

  pipe_ctrl_seq u_dut (
    .clk              (clk),
    .resetn           (resetn),
    .stallreq_i       (stallreq_i),
    .excepttype_i     (excepttype_i),
    .cp0_epc_i        (cp0_epc_i),
    .current_pc_i     (current_pc_i),
    .redirect_ready_i (redirect_ready_i),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .new_pc_o         (new_pc_o),
    .redirect_valid_o (redirect_valid_o),
    .busy_o           (busy_o),
    .stall_cycles_o   (stall_cycles_o)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  pipe_ctrl_seq #(.CNT_W(4)) u_sat (
    .clk              (clk),
    .resetn           (resetn),
    .stallreq_i       (stallreq_i),
    .excepttype_i     (excepttype_i),
    .cp0_epc_i        (cp0_epc_i),
    .current_pc_i     (current_pc_i),
    .redirect_ready_i (redirect_ready_i),
    .stall_o          (s_stall_o),
    .flush_o          (s_flush_o),
    .new_pc_o         (s_new_pc_o),
    .redirect_valid_o (s_redirect_valid_o),
    .busy_o           (s_busy_o),
    .stall_cycles_o   (s_stall_cycles_o)
  );

  int checks   = 0;
  int failures = 0;

  localparam logic [8:0] MASKS [5] = '{9'h0FF, 9'h0FF, 9'h0FF, 9'h01F, 9'h00F};

  bit              m_hold;
  bit              m_flush;
  bit              m_redir;
  logic [31:0]     m_target;
  longint unsigned m_cnt;

  typedef struct {
    logic [31:0] exc;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] target;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic [31:0] e, input logic [31:0] epc,
                                             input logic [31:0] pc);
    if (e == 32'hffffffff) return pc + 32'd4;
    if (e == 32'h0e) return epc;
    if (e == 32'h11 || e == 32'h13) return 32'hbfc00200;
    if (e inside {32'h01, 32'h04, 32'h05, 32'h08, 32'h09, 32'h0a, 32'h0c, 32'h0d,
                  32'h12, 32'h14, 32'h15}) return 32'hbfc00380;
    return 32'h0;
  endfunction

  function automatic logic [8:0] exp_stall();
    logic [8:0] s = 9'h0;
    for (int i = 0; i < 5; i++) if (stallreq_i[i]) s = s | MASKS[i];
    if (m_flush) return 9'h0;
    if (m_hold) return 9'h1FF;
    if (m_redir) s[0] = 1'b1;
    return s;
  endfunction

  task automatic model_reset();
    m_hold = 0; m_flush = 0; m_redir = 0; m_target = 32'h0; m_cnt = 0;
  endtask

  task automatic step();
    logic [8:0]  es;
    logic [31:0] ep;
    @(negedge clk);
    es = exp_stall();
    ep = (m_hold || m_flush || m_redir) ? m_target : 32'h0;
    chk("stall_o", 64'(stall_o), 64'(es));
    chk("flush_o", 64'(flush_o), 64'(m_flush));
    chk("redirect_valid_o", 64'(redirect_valid_o), 64'(m_redir));
    chk("busy_o", 64'(busy_o), 64'(m_hold || m_flush || m_redir));
    chk("new_pc_o", 64'(new_pc_o), 64'(ep));
    chk("stall_cycles_o", 64'(stall_cycles_o), (m_cnt > 64'hffffffff) ? 64'hffffffff : m_cnt);
    chk("sat_stall_cycles_o", 64'(s_stall_cycles_o), (m_cnt > 64'd15) ? 64'd15 : m_cnt);
    @(posedge clk);
    if (!resetn) begin
      model_reset();
    end else begin
      if (es != 9'h0) m_cnt++;
      if (m_redir) begin
        if (redirect_ready_i) m_redir = 0;
      end else if (m_flush) begin
        m_flush = 0;
        m_redir = 1;
      end else if (m_hold) begin
        if ((stallreq_i & 5'b00110) == 5'b0) begin
          m_hold  = 0;
          m_flush = 1;
        end
      end else if (excepttype_i != 32'h0) begin
        m_target = ref_target(excepttype_i, cp0_epc_i, current_pc_i);
        if ((stallreq_i & 5'b00110) != 5'b0) m_hold = 1;
        else m_flush = 1;
      end
    end
    #1;
  endtask

  logic [31:0] codes [16] = '{32'h01, 32'h04, 32'h05, 32'h08, 32'h09, 32'h0a, 32'h0c, 32'h0d,
                              32'h0e, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'hffffffff, 32'h07};

  initial begin
    vt[0] = '{32'h08,       32'h0,        32'h0,        32'hbfc00380};
    vt[1] = '{32'h0e,       32'h80001234, 32'h0,        32'h80001234};
    vt[2] = '{32'hffffffff, 32'h0,        32'hfffffffc, 32'h00000000};
    vt[3] = '{32'h13,       32'h0,        32'h0,        32'hbfc00200};
    vt[4] = '{32'h07,       32'h0,        32'h0,        32'h00000000};
    vt[5] = '{32'h11,       32'h0,        32'h0,        32'hbfc00200};
    vt[6] = '{32'h01,       32'h0,        32'h0,        32'hbfc00380};
    vt[7] = '{32'hffffffff, 32'h0,        32'h00000100, 32'h00000104};
    vt[8] = '{32'h15,       32'h0,        32'h0,        32'hbfc00380};
    vt[9] = '{32'h10,       32'h0,        32'h0,        32'h00000000};

    resetn = 1'b0; stallreq_i = 5'b0; excepttype_i = 32'h0; cp0_epc_i = 32'h0;
    current_pc_i = 32'h0; redirect_ready_i = 1'b1;
    model_reset();
    step(); step();
    resetn = 1'b1;

    stallreq_i = 5'b01000;
    repeat (3) step();
    chk("tp1_stall", 64'(stall_o), 64'h01F);
    stallreq_i = 5'b0;

    redirect_ready_i = 1'b0;
    excepttype_i = 32'h08;
    step();
    excepttype_i = 32'h0;
    step();
    chk("tp2_valid", 64'(redirect_valid_o), 64'h1);
    chk("tp2_target", 64'(new_pc_o), 64'hbfc00380);
    repeat (3) step();
    chk("tp2_hold", 64'(new_pc_o), 64'hbfc00380);
    redirect_ready_i = 1'b1;
    step();
    chk("tp2_back_run", 64'(busy_o), 64'h0);

    stallreq_i = 5'b00010; excepttype_i = 32'h0e; cp0_epc_i = 32'h80001234;
    step();
    excepttype_i = 32'h08;
    repeat (4) begin
      chk("tp3_wait_stall", 64'(stall_o), 64'h1FF);
      chk("tp3_no_flush", 64'(flush_o), 64'h0);
      step();
    end
    excepttype_i = 32'h0; stallreq_i = 5'b0;
    step();
    chk("tp3_flush", 64'(flush_o), 64'h1);
    step();
    chk("tp3_target", 64'(new_pc_o), 64'h80001234);
    step();

    for (int k = 0; k < 10; k++) begin
      excepttype_i = vt[k].exc; cp0_epc_i = vt[k].epc; current_pc_i = vt[k].pc;
      step();
      excepttype_i = 32'h0;
      step();
      chk($sformatf("vec_target_%0d", k), 64'(new_pc_o), 64'(vt[k].target));
      step();
    end

    redirect_ready_i = 1'b0; excepttype_i = 32'h08;
    step();
    excepttype_i = 32'h0;
    step();
    chk("tp5_valid_before", 64'(redirect_valid_o), 64'h1);
    #2 resetn = 1'b0;
    #1;
    chk("tp5_valid_async", 64'(redirect_valid_o), 64'h0);
    chk("tp5_newpc_async", 64'(new_pc_o), 64'h0);
    chk("tp5_cnt_async", 64'(stall_cycles_o), 64'h0);
    model_reset();
    step();
    resetn = 1'b1; redirect_ready_i = 1'b1;
    repeat (3) step();

    for (int n = 0; n < 400; n++) begin
      stallreq_i = 5'($urandom);
      if ($urandom_range(0, 1) == 0) stallreq_i = stallreq_i & 5'b11001;
      excepttype_i = ($urandom_range(0, 7) == 0) ? codes[$urandom_range(0, 15)] : 32'h0;
      cp0_epc_i = $urandom;
      current_pc_i = $urandom;
      redirect_ready_i = ($urandom_range(0, 2) != 0);
      step();
    end

    excepttype_i = 32'h0; redirect_ready_i = 1'b1; stallreq_i = 5'b11111;
    repeat (20) step();
    chk("tp6_saturate", 64'(s_stall_cycles_o), 64'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
